branch_predictor: RTL

- Fetch-stage gshare direction predictor with a direct-mapped BTB.
- Produces the prediction bundle (pred_taken, pht_idx, btb_hit, btb_target) that the IF/ID register carries into the decode/execute register, plus the predicted next PC.
- Trains from execute-stage resolution, non-speculatively.
- Keeps branch and mispredict performance counters.

---
 rtl/bp_pkg.sv | 38 +++
 rtl/branch_predictor_if.sv | 35 +++
 rtl/bp_btb.sv | 35 +++
 rtl/branch_predictor.sv | 131 +++++++++++++
 4 files changed

// File: rtl/bp_pkg.sv
// Shared types and sizing for the gshare branch predictor and its BTB.
// Index widths are fixed to match the pht_idx field carried down the pipeline.
package bp_pkg;

    localparam int PHT_IDX_W = 5;
    localparam int BTB_IDX_W = 4;
    localparam int BTB_TAG_W = 32 - BTB_IDX_W - 2;
    localparam int PHT_SIZE  = 1 << PHT_IDX_W;
    localparam int BTB_SIZE  = 1 << BTB_IDX_W;

    typedef struct packed {
        logic                 valid;
        logic [BTB_TAG_W-1:0] tag;
        logic [31:0]          target;
    } btb_entry_t;

    typedef enum logic [1:0] {
        SNT = 2'd0,
        WNT = 2'd1,
        WT  = 2'd2,
        ST  = 2'd3
    } ctr2_t;

    // Two-bit saturating counter step; never wraps at either end.
    function automatic ctr2_t ctr_next(input ctr2_t ctr, input logic taken);
        ctr2_t nxt;
        nxt = ctr;
        case (ctr)
            SNT:     nxt = taken ? WNT : SNT;
            WNT:     nxt = taken ? WT  : SNT;
            WT:      nxt = taken ? ST  : WNT;
            ST:      nxt = taken ? ST  : WT;
            default: nxt = WNT;
        endcase
        return nxt;
    endfunction

endpackage

// File: rtl/branch_predictor_if.sv
// Fetch-lookup and execute-update bundle between the pipeline and the predictor.
// The pipeline side is the master; the predictor is the slave.
interface branch_predictor_if;
    import bp_pkg::*;

    logic [31:0]          F_PC;
    logic                 F_pred_taken;
    logic [PHT_IDX_W-1:0] F_pht_idx;
    logic                 F_btb_hit;
    logic [31:0]          F_btb_target;
    logic [31:0]          F_next_pc;

    logic                 E_upd_valid;
    logic                 E_upd_cond;
    logic                 E_upd_taken;
    logic [PHT_IDX_W-1:0] E_upd_pht_idx;
    logic [31:0]          E_upd_PC;
    logic [31:0]          E_upd_target;
    logic                 E_upd_mispredict;

    modport master (
        output F_PC,
        input  F_pred_taken, F_pht_idx, F_btb_hit, F_btb_target, F_next_pc,
        output E_upd_valid, E_upd_cond, E_upd_taken, E_upd_pht_idx,
        output E_upd_PC, E_upd_target, E_upd_mispredict
    );

    modport slave (
        input  F_PC,
        output F_pred_taken, F_pht_idx, F_btb_hit, F_btb_target, F_next_pc,
        input  E_upd_valid, E_upd_cond, E_upd_taken, E_upd_pht_idx,
        input  E_upd_PC, E_upd_target, E_upd_mispredict
    );

endinterface

// File: rtl/bp_btb.sv
// Direct-mapped branch target buffer: combinational read, one registered write port.
// A write in the same cycle as a read of that entry is not bypassed to the read.
module bp_btb
    import bp_pkg::*;
(
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [BTB_IDX_W-1:0] rd_idx,
    output btb_entry_t           rd_entry,
    input  logic                 wr_en,
    input  logic [BTB_IDX_W-1:0] wr_idx,
    input  btb_entry_t           wr_entry
);

    btb_entry_t entry_arr [BTB_SIZE];

    generate
        for (genvar gi = 0; gi < BTB_SIZE; gi++) begin : g_entry
            btb_entry_t entry_reg;

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    entry_reg <= '0;
                end else if (wr_en && (wr_idx == BTB_IDX_W'(gi))) begin
                    entry_reg <= wr_entry;
                end
            end

            assign entry_arr[gi] = entry_reg;
        end
    endgenerate

    assign rd_entry = entry_arr[rd_idx];

endmodule

// File: rtl/branch_predictor.sv
// Fetch-stage gshare direction predictor with a direct-mapped BTB, trained
// non-speculatively from execute-stage resolution, plus saturating perf counters.
module branch_predictor
    import bp_pkg::*;
#(
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    branch_predictor_if.slave bp,
    output logic [CNT_W-1:0] br_count,
    output logic [CNT_W-1:0] mispred_count
);

    logic [PHT_IDX_W-1:0] ghr_reg;
    logic [PHT_IDX_W-1:0] ghr_next;
    logic [CNT_W-1:0]     br_count_reg;
    logic [CNT_W-1:0]     br_count_next;
    logic [CNT_W-1:0]     mispred_count_reg;
    logic [CNT_W-1:0]     mispred_count_next;

    ctr2_t                pht_arr [PHT_SIZE];
    logic [PHT_IDX_W-1:0] lookup_idx;
    logic [1:0]           lookup_ctr;
    logic                 pht_upd;

    logic [BTB_IDX_W-1:0] btb_rd_idx;
    logic [BTB_IDX_W-1:0] btb_wr_idx;
    btb_entry_t           btb_rd_entry;
    btb_entry_t           btb_wr_entry;
    logic                 btb_wr_en;
    logic                 btb_hit;
    logic                 pred_taken;

    // ------------------------------------------------------------------
    // Lookup path (pure combinational, reads pre-update state)
    // ------------------------------------------------------------------
    assign lookup_idx = bp.F_PC[PHT_IDX_W+1:2] ^ ghr_reg;
    assign lookup_ctr = pht_arr[lookup_idx];
    assign btb_rd_idx = bp.F_PC[BTB_IDX_W+1:2];
    assign btb_hit    = btb_rd_entry.valid &&
                        (btb_rd_entry.tag == bp.F_PC[31:BTB_IDX_W+2]);
    // Without a target there is nowhere to redirect, so a miss is never taken.
    assign pred_taken = btb_hit && lookup_ctr[1];

    assign bp.F_pred_taken = pred_taken;
    assign bp.F_pht_idx    = lookup_idx;
    assign bp.F_btb_hit    = btb_hit;
    assign bp.F_btb_target = btb_hit ? btb_rd_entry.target : 32'h0;
    assign bp.F_next_pc    = pred_taken ? btb_rd_entry.target : (bp.F_PC + 32'd4);

    // ------------------------------------------------------------------
    // Pattern history table
    // ------------------------------------------------------------------
    assign pht_upd = bp.E_upd_valid && bp.E_upd_cond;

    generate
        for (genvar gi = 0; gi < PHT_SIZE; gi++) begin : g_pht
            ctr2_t ctr_reg;

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    ctr_reg <= WNT;
                end else if (pht_upd && (bp.E_upd_pht_idx == PHT_IDX_W'(gi))) begin
                    ctr_reg <= ctr_next(ctr_reg, bp.E_upd_taken);
                end
            end

            assign pht_arr[gi] = ctr_reg;
        end
    endgenerate

    // ------------------------------------------------------------------
    // Branch target buffer; only taken outcomes carry a useful target
    // ------------------------------------------------------------------
    assign btb_wr_en           = bp.E_upd_valid && bp.E_upd_taken;
    assign btb_wr_idx          = bp.E_upd_PC[BTB_IDX_W+1:2];
    assign btb_wr_entry.valid  = 1'b1;
    assign btb_wr_entry.tag    = bp.E_upd_PC[31:BTB_IDX_W+2];
    assign btb_wr_entry.target = bp.E_upd_target;

    bp_btb u_btb (
        .clk      (clk),
        .rst_n    (rst_n),
        .rd_idx   (btb_rd_idx),
        .rd_entry (btb_rd_entry),
        .wr_en    (btb_wr_en),
        .wr_idx   (btb_wr_idx),
        .wr_entry (btb_wr_entry)
    );

    // ------------------------------------------------------------------
    // Global history and performance counters
    // ------------------------------------------------------------------
    always_comb begin
        ghr_next           = ghr_reg;
        br_count_next      = br_count_reg;
        mispred_count_next = mispred_count_reg;
        if (pht_upd) begin
            ghr_next = {ghr_reg[PHT_IDX_W-2:0], bp.E_upd_taken};
        end
        if (bp.E_upd_valid) begin
            if (br_count_reg != {CNT_W{1'b1}}) begin
                br_count_next = br_count_reg + CNT_W'(1);
            end
            if (bp.E_upd_mispredict && (mispred_count_reg != {CNT_W{1'b1}})) begin
                mispred_count_next = mispred_count_reg + CNT_W'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ghr_reg           <= '0;
            br_count_reg      <= '0;
            mispred_count_reg <= '0;
        end else begin
            ghr_reg           <= ghr_next;
            br_count_reg      <= br_count_next;
            mispred_count_reg <= mispred_count_next;
        end
    end

    assign br_count      = br_count_reg;
    assign mispred_count = mispred_count_reg;

    // Word-aligned PCs: the byte-offset bits carry no information here.
    logic unused_pc_bits;
    assign unused_pc_bits = &{1'b0, bp.F_PC[1:0], bp.E_upd_PC[1:0]};

endmodule
